serial_mac_unit: RTL and testbench
==================================

SERIAL_MAC_UNIT -- requirements
Module: serial_mac_unit

Interface
REQ-001 SHALL provide parameter Pa, default 8, activation width in bits; equals the upstream activation shift-register depth.
REQ-002 SHALL provide parameter Pw, default 8, signed two's-complement weight width.
REQ-003 SHALL provide parameter Pacc, default 24, accumulator width; Pacc >= Pa+Pw.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, request to process one activation/weight pair.
REQ-007 SHALL have port acc_clr, input, 1, clears the accumulator.
REQ-008 SHALL have port weight, input, Pw, signed weight operand.
REQ-009 SHALL have port ser_in, input, 1, activation bit stream from the shift register, LSB first.
REQ-010 SHALL have port sr_w_en, output, 1, parallel-load strobe to the shift register.
REQ-011 SHALL have port sr_s_en, output, 1, rotate strobe to the shift register.
REQ-012 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-013 SHALL have port done, output, 1, one-cycle pulse when acc_out is updated.
REQ-014 SHALL have port acc_out, output, Pacc, signed accumulator value.

Function
REQ-015 SHALL implement the FSM states IDLE, LOAD, SHIFT, and DONE.
REQ-016 IDLE -> LOAD SHALL occur when start=1 is sampled; in all other states start SHALL be ignored.
REQ-017 LOAD SHALL last 1 cycle: sr_w_en=1, sr_s_en=0, and weight is captured into an internal register; weight is don't-care afterwards.
REQ-018 SHIFT SHALL last exactly Pa cycles, with bit counter k=0..Pa-1, sr_s_en=1, and sr_w_en=0; ser_in sampled in SHIFT cycle k is activation bit k.
REQ-019 In SHIFT, when ser_in=1 the partial sum SHALL add the sign-extended captured weight shifted left by k; when ser_in=0 the partial sum is unchanged.
REQ-020 After the last SHIFT cycle the FSM SHALL enter DONE for 1 cycle, during which acc_out = previous acc_out + product and done=1; DONE -> IDLE follows.
REQ-021 Latency SHALL be Pa+2 cycles from the start sample edge to done; one operation occupies Pa+3 cycles, so the next start is accepted in the cycle after DONE.
REQ-022 sr_w_en and sr_s_en SHALL never be high together and SHALL both be 0 in IDLE and DONE.
REQ-023 Accumulation SHALL wrap modulo 2^Pacc with no saturation and no overflow flag.
REQ-024 acc_clr SHALL be honoured only in IDLE, where it sets acc_out to 0 on the next edge; it SHALL be ignored while busy.
REQ-025 When acc_clr and start occur in the same IDLE cycle, the accumulator SHALL clear and the new product SHALL add onto 0.
REQ-026 acc_out SHALL hold its value between operations and change only in DONE or on clear.

Reset
REQ-027 When rst_n=0 the block SHALL immediately enter IDLE and set the counter, partial sum, captured weight, and acc_out to 0, and set sr_w_en, sr_s_en, busy, and done to 0.
REQ-028 A reset during LOAD or SHIFT SHALL abort the operation with no partial result retained; after release the FSM SHALL wait in IDLE for start.

Configuration
REQ-029 When macro SERIAL_MAC_SIGNED_ACT_EN is defined, activation SHALL be two's complement: at k=Pa-1 with ser_in=1 the shifted weight is subtracted instead of added.
REQ-030 When SERIAL_MAC_SIGNED_ACT_EN is undefined, activation SHALL be unsigned and every bit, including k=Pa-1, adds.

Verification (Pa=8, Pw=8, Pacc=24)
REQ-031 The bench SHALL cover: reset, acc_clr, activation 0x03, weight 5, start -> done exactly 10 cycles after start, acc_out=15, and sr_s_en high for exactly 8 cycles.
REQ-032 The bench SHALL cover: after REQ-031 without clear, activation 0x02 with weight -4 -> acc_out=7.
REQ-033 The bench SHALL cover: acc_clr, activation 0xFF, weight 7 -> acc_out=-7 with SERIAL_MAC_SIGNED_ACT_EN defined, and 1785 without it.
REQ-034 The bench SHALL cover: start pulsed again during SHIFT -> ignored, a single done pulse, and the result unaffected.
REQ-035 The bench SHALL cover: rst_n asserted in SHIFT cycle 4 -> busy=0 and acc_out=0 immediately, and no done pulse.
REQ-036 The bench SHALL cover: acc_clr held through a busy operation -> ignored, and acc_out equals the accumulated value at done.

Source files
------------

// File: rtl/serial_mac_unit.sv
// Bit-serial multiply-accumulate: one activation bit per cycle from an external shift register.
// Define SERIAL_MAC_SIGNED_ACT_EN to treat the activation as two's complement (MSB subtracts).
module serial_mac_unit #(
  parameter int Pa   = 8,
  parameter int Pw   = 8,
  parameter int Pacc = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            acc_clr,
  input  logic [Pw-1:0]   weight,
  input  logic            ser_in,
  output logic            sr_w_en,
  output logic            sr_s_en,
  output logic            busy,
  output logic            done,
  output logic [Pacc-1:0] acc_out
);

  localparam int CW = (Pa > 1) ? $clog2(Pa) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [Pw-1:0]   wgt_q;
  logic [Pacc-1:0] psum_q;
  logic [Pacc-1:0] acc_q;
  logic            sr_w_en_q;
  logic            sr_s_en_q;
  logic            busy_q;
  logic            done_q;

  logic [Pacc-1:0] wgt_ext;
  logic [Pacc-1:0] term;
  logic [Pacc-1:0] psum_d;
  logic            last_bit;

  assign wgt_ext  = {{(Pacc-Pw){wgt_q[Pw-1]}}, wgt_q};
  assign term     = wgt_ext << cnt_q;
  assign last_bit = (cnt_q == CW'(Pa-1));

  always_comb begin
    psum_d = psum_q;
    if (ser_in) begin
`ifdef SERIAL_MAC_SIGNED_ACT_EN
      if (last_bit) psum_d = psum_q - term;
      else          psum_d = psum_q + term;
`else
      psum_d = psum_q + term;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wgt_q     <= '0;
      psum_q    <= '0;
      acc_q     <= '0;
      sr_w_en_q <= 1'b0;
      sr_s_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Clearing here lets a same-cycle start accumulate onto zero.
          if (acc_clr) acc_q <= '0;
          if (start) begin
            state_q   <= LOAD;
            sr_w_en_q <= 1'b1;
            busy_q    <= 1'b1;
            psum_q    <= '0;
            cnt_q     <= '0;
          end
        end
        LOAD: begin
          wgt_q     <= weight;
          state_q   <= SHIFT;
          sr_w_en_q <= 1'b0;
          sr_s_en_q <= 1'b1;
        end
        SHIFT: begin
          psum_q <= psum_d;
          cnt_q  <= cnt_q + 1'b1;
          if (last_bit) begin
            state_q   <= DONE;
            sr_s_en_q <= 1'b0;
            acc_q     <= acc_q + psum_d;
            done_q    <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sr_w_en = sr_w_en_q;
  assign sr_s_en = sr_s_en_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign acc_out = acc_q;

endmodule

// File: tb/tb_serial_mac_unit.sv
// Randomized bench for serial_mac_unit with an arithmetic MAC reference and a shift-register model.
module tb_serial_mac_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        acc_clr = 1'b0;
  logic [7:0]  weight = '0;
  logic        ser_in;
  logic        sr_w_en, sr_s_en, busy, done;
  logic [23:0] acc_out;

  logic [7:0]  act_reg = '0;
  logic [7:0]  sr_m = '0;
  logic [23:0] acc_m = '0;

  int n_chk = 0;
  int n_bad = 0;

  serial_mac_unit #(.Pa(8), .Pw(8), .Pacc(24)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .acc_clr(acc_clr),
    .weight(weight), .ser_in(ser_in), .sr_w_en(sr_w_en), .sr_s_en(sr_s_en),
    .busy(busy), .done(done), .acc_out(acc_out)
  );

  always #5 clk = ~clk;

  // Upstream activation shift register: parallel load, then rotate right (LSB first).
  always @(posedge clk) begin
    if (sr_w_en)      sr_m <= act_reg;
    else if (sr_s_en) sr_m <= {sr_m[0], sr_m[7:1]};
  end
  assign ser_in = sr_m[0];

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int act_value(input logic [7:0] a);
`ifdef SERIAL_MAC_SIGNED_ACT_EN
    return int'($signed(a));
`else
    return int'(a);
`endif
  endfunction

  task automatic do_op(input string tag, input logic [7:0] act, input logic [7:0] w,
                       input bit clr_first, input bit extra_start, input bit hold_clr);
    logic [23:0] old_acc;
    int done_cyc, dones, s_cnt, w_cnt, overlap;
    done_cyc = -1; dones = 0; s_cnt = 0; w_cnt = 0; overlap = 0;
    @(negedge clk);
    act_reg = act;
    weight  = w;
    start   = 1'b1;
    acc_clr = clr_first | hold_clr;
    if (clr_first | hold_clr) acc_m = '0;
    old_acc = acc_m;
    acc_m   = acc_m + 24'(act_value(act) * int'($signed(w)));
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (!hold_clr || cyc >= 10) acc_clr = 1'b0;
      if (cyc == 2) weight = 8'($urandom);
      if (extra_start && cyc == 4) start = 1'b1;
      if (sr_s_en) s_cnt++;
      if (sr_w_en) w_cnt++;
      if (sr_w_en && sr_s_en) overlap++;
      if (cyc == 9) check_val({tag, "_hold"}, acc_out, old_acc);
      if (done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
        check_val({tag, "_acc"}, acc_out, acc_m);
      end
      if (cyc == 11) check_val({tag, "_busy_low"}, busy, 0);
    end
    check_val({tag, "_latency"}, done_cyc, 10);
    check_val({tag, "_ndone"}, dones, 1);
    check_val({tag, "_s_en"}, s_cnt, 8);
    check_val({tag, "_w_en"}, w_cnt, 1);
    check_val({tag, "_overlap"}, overlap, 0);
    check_val({tag, "_final"}, acc_out, acc_m);
  endtask

  initial begin
    int dones;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_w_en", sr_w_en, 0);
    check_val("rst_s_en", sr_s_en, 0);
    check_val("rst_acc", acc_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("basic", 8'h03, 8'd5, 1'b1, 1'b0, 1'b0);
    check_val("basic_15", acc_out, 15);
    do_op("neg_w", 8'h02, 8'hFC, 1'b0, 1'b0, 1'b0);
    check_val("neg_w_7", acc_out, 7);
    do_op("all_ones", 8'hFF, 8'd7, 1'b1, 1'b0, 1'b0);
`ifdef SERIAL_MAC_SIGNED_ACT_EN
    check_val("all_ones_val", acc_out, 24'hFFFFF9);
`else
    check_val("all_ones_val", acc_out, 1785);
`endif
    do_op("restart", 8'($urandom), 8'($urandom), 1'b0, 1'b1, 1'b0);
    do_op("clr_held", 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b1);

    // Reset during SHIFT cycle k=4 must abort with nothing retained.
    dones = 0;
    @(negedge clk);
    act_reg = 8'hB7;
    weight  = 8'h35;
    start   = 1'b1;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) dones++;
      if (cyc == 6) begin
        check_val("rst_mid_s_en_before", sr_s_en, 1);
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_busy", busy, 0);
        check_val("rst_mid_acc", acc_out, 0);
        check_val("rst_mid_s_en", sr_s_en, 0);
      end
      if (cyc == 8) rst_n = 1'b1;
    end
    acc_m = '0;
    check_val("rst_mid_ndone", dones, 0);
    check_val("rst_mid_idle", busy, 0);
    check_val("rst_mid_acc_after", acc_out, 0);

    for (int i = 0; i < 25; i++)
      do_op("rand", 8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0), 1'b0, 1'b0);

    @(negedge clk);
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    acc_m = '0;
    check_val("idle_clr", acc_out, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
